doorbell_chime_seq: RTL and testbench
=====================================

Name: doorbell_chime_seq

Overview:
- Upstream sequencer for the doorbell chime multiplexer.
- Debounces the doorbell push-button and, on a clean press, plays a two-tone "ding-dong".
- Generates square-wave tone A, then tone B, and drives the sel line that the downstream mux uses to choose between them.
- Outputs busy/done status for the rest of the doorbell system.

Parameters:
- DEBOUNCE, 4: consecutive cycles the synchronised button must differ from its debounced state before the debounced state flips (>=1).
- DIV_A, 3: half-period of tone A, in clk cycles (>=1).
- DIV_B, 5: half-period of tone B, in clk cycles (>=1).
- DUR_A, 20: length of the DING phase, in clk cycles (>=1).
- DUR_B, 30: length of the DONG phase, in clk cycles (>=1).

Ports:
- clk  input  1  system clock; all state on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- button  input  1  raw asynchronous push-button, active high.
- tone_a  output  1  square wave A (feeds mux input A).
- tone_b  output  1  square wave B (feeds mux input B).
- sel  output  1  0 = tone A phase, 1 = tone B phase (feeds mux sel).
- busy  output  1  high while DING or DONG.
- done  output  1  single-cycle pulse when a chime completes.

Behaviour:
- Interface: one clock, clk. Reset rst_n is asynchronous, active-low.
- Reset: tone_a=0, tone_b=0, sel=0, busy=0, done=0, FSM=IDLE. Sync flops, debounced state and all counters are cleared.
- Reset asserted mid-chime: outputs clear immediately, without waiting for clk. After release, the block waits for a fresh debounced press.
- Synchroniser: button passes through 2 flops (s1, s2).
- Debounce:
  - The counter increments each cycle s2 != deb, and clears whenever s2 == deb.
  - When the count reaches DEBOUNCE, deb takes the value of s2 and the counter clears.
  - A press event is the cycle where deb goes 0->1.
  - Glitches shorter than DEBOUNCE cycles are ignored.
- FSM states: IDLE, DING, DONG.
- IDLE -> DING on a press event, at the same edge deb rises.
  - busy rises at the (DEBOUNCE+2)th rising edge after button is first sampled high.
- DING:
  - Exactly DUR_A cycles; sel=0, busy=1, tone_b=0.
  - tone_a starts at 0 on entry and toggles every DIV_A cycles.
  - Then -> DONG.
- DONG:
  - Exactly DUR_B cycles; sel=1, busy=1, tone_a=0.
  - tone_b starts at 0 on entry and toggles every DIV_B cycles.
  - Then -> IDLE.
- done: high for exactly the first IDLE cycle after DONG; low at all other times.
- In IDLE, tone_a=tone_b=0 and sel=0.
- Counter widths: $clog2 of the maximum count + 1. Counters never wrap within a phase; they reload at each state entry.
- Button held through an entire chime: no second chime. deb must return to 0 and a new 0->1 debounced edge must occur.
- Press event while busy: ignored, unless the optional feature below is compiled in.
- Press event on the same edge as DONG->IDLE: ignored. A press counts only if the FSM is already in IDLE.

Optional Feature:
- Macro: CHIME_RETRIGGER_EN.
- Defined: a press event during DONG restarts DING immediately. The duration and tone counters reload, tone_b=0, sel=0. No done pulse is issued for the aborted chime. A press during DING is still ignored.
- Undefined: all presses while busy are ignored.

Test Plan:
- Reset: drive rst_n=0 mid-DING (default parameters) -> all outputs 0 immediately, without a clk edge; after release, remain IDLE with button=0.
- Bounce: button high for 3 cycles, low 2, high 2, then low -> busy never asserts, tone_a/tone_b stay 0.
- Clean press: button high from cycle 0 (defaults) -> busy=1 at edge 6; sel=0 for 20 cycles with tone_a period 6; then sel=1 for 30 cycles with tone_b period 10; done=1 for one cycle; busy=0.
- Held button: button held high for 200 cycles -> exactly one chime and one done pulse.
- Press during DONG, macro undefined -> chime completes normally; total busy = 50 cycles.
- Press during DONG, CHIME_RETRIGGER_EN defined -> sel returns to 0 at the press edge; a full 20+30-cycle chime follows; exactly one done pulse.

Source files
------------

// File: rtl/doorbell_chime_seq.sv
// Doorbell chime sequencer: debounces the button and plays tone A then tone B.
// Optional macro CHIME_RETRIGGER_EN: a press during DONG restarts the chime at DING.
module doorbell_chime_seq #(
    parameter int DEBOUNCE = 4,
    parameter int DIV_A    = 3,
    parameter int DIV_B    = 5,
    parameter int DUR_A    = 20,
    parameter int DUR_B    = 30
) (
    input  logic clk,
    input  logic rst_n,
    input  logic button,
    output logic tone_a,
    output logic tone_b,
    output logic sel,
    output logic busy,
    output logic done
);
    localparam int DUR_MAX = (DUR_A > DUR_B) ? DUR_A : DUR_B;
    localparam int DIV_MAX = (DIV_A > DIV_B) ? DIV_A : DIV_B;
    localparam int DB_W    = $clog2(DEBOUNCE + 1);
    localparam int DUR_W   = $clog2(DUR_MAX + 1);
    localparam int DIV_W   = $clog2(DIV_MAX + 1);

    typedef enum logic [1:0] {IDLE, DING, DONG} state_t;

    state_t           state, state_next;
    logic             s1, s2, deb;
    logic [DB_W-1:0]  db_cnt;
    logic [DUR_W-1:0] dur_cnt;
    logic [DIV_W-1:0] div_cnt;
    logic             tone;
    logic             deb_flip, press, phase_end, tone_flip;

    // deb flips on the cycle the mismatch count would reach DEBOUNCE
    assign deb_flip = (s2 != deb) && (db_cnt == DB_W'(DEBOUNCE - 1));
    assign press    = deb_flip && s2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1     <= 1'b0;
            s2     <= 1'b0;
            deb    <= 1'b0;
            db_cnt <= '0;
        end else begin
            s1 <= button;
            s2 <= s1;
            if (s2 == deb) begin
                db_cnt <= '0;
            end else if (deb_flip) begin
                deb    <= s2;
                db_cnt <= '0;
            end else begin
                db_cnt <= db_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        phase_end  = 1'b0;
        tone_flip  = 1'b0;
        state_next = state;
        case (state)
            IDLE: begin
                if (press) state_next = DING;
            end
            DING: begin
                phase_end = (dur_cnt == DUR_W'(DUR_A - 1));
                tone_flip = (div_cnt == DIV_W'(DIV_A - 1));
                if (phase_end) state_next = DONG;
            end
            DONG: begin
                phase_end = (dur_cnt == DUR_W'(DUR_B - 1));
                tone_flip = (div_cnt == DIV_W'(DIV_B - 1));
                if (phase_end) state_next = IDLE;
`ifdef CHIME_RETRIGGER_EN
                if (press) state_next = DING;
`endif
            end
            default: state_next = IDLE;
        endcase
    end

    // Any state change (including a DONG->DING retrigger) reloads the phase counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            dur_cnt <= '0;
            div_cnt <= '0;
            tone    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state <= state_next;
            done  <= (state == DONG) && (state_next == IDLE);
            if (state_next != state || state == IDLE) begin
                dur_cnt <= '0;
                div_cnt <= '0;
                tone    <= 1'b0;
            end else begin
                dur_cnt <= dur_cnt + 1'b1;
                if (tone_flip) begin
                    div_cnt <= '0;
                    tone    <= ~tone;
                end else begin
                    div_cnt <= div_cnt + 1'b1;
                end
            end
        end
    end

    assign tone_a = tone && (state == DING);
    assign tone_b = tone && (state == DONG);
    assign sel    = (state == DONG);
    assign busy   = (state != IDLE);
endmodule

// File: tb/tb_doorbell_chime_seq.sv
// Scoreboard bench for doorbell_chime_seq: expected {tone_a,tone_b,sel,busy,done}
// per cycle is derived from the chime timeline and queued as the button is driven.
module tb_doorbell_chime_seq;
    localparam int DEBOUNCE = 4;
    localparam int DIV_A    = 3;
    localparam int DIV_B    = 5;
    localparam int DUR_A    = 20;
    localparam int DUR_B    = 30;
    localparam int LAT      = DEBOUNCE + 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic button = 1'b0;
    logic tone_a, tone_b, sel, busy, done;

    int vectors = 0;
    int errors  = 0;
    logic [4:0] exp_q[$];
    logic [4:0] got, want;

    doorbell_chime_seq #(
        .DEBOUNCE(DEBOUNCE), .DIV_A(DIV_A), .DIV_B(DIV_B), .DUR_A(DUR_A), .DUR_B(DUR_B)
    ) dut (
        .clk(clk), .rst_n(rst_n), .button(button),
        .tone_a(tone_a), .tone_b(tone_b), .sel(sel), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // Expected outputs k edges into a test whose chime started at edge p (p<0: no chime)
    function automatic logic [4:0] model(int k, int p);
        int i;
        if (p < 0) return 5'b0;
        i = k - p;
        if (i < 0) return 5'b0;
        if (i < DUR_A) return {((i / DIV_A) % 2) == 1, 1'b0, 1'b0, 1'b1, 1'b0};
        if (i < DUR_A + DUR_B) return {1'b0, (((i - DUR_A) / DIV_B) % 2) == 1, 1'b1, 1'b1, 1'b0};
        if (i == DUR_A + DUR_B) return 5'b00001;
        return 5'b0;
    endfunction

    // Drive one cycle of stimulus, queue its expectation, advance past the edge
    task automatic tick(input logic b, input logic [4:0] e);
        button = b;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        got  = {tone_a, tone_b, sel, busy, done};
        want = exp_q.pop_front();
    endtask

    task automatic settle(input string name);
        for (int k = 1; k <= 12; k++) begin
            tick(1'b0, 5'b0);
            vectors++;
            if (got !== want) begin
                errors++;
                $display("FAIL %s idle k=%0d got=%b want=%b", name, k, got, want);
            end
        end
    endtask

    task automatic test_reset();
        got = {tone_a, tone_b, sel, busy, done};
        vectors++;
        if (got !== 5'b0) begin
            errors++;
            $display("FAIL reset_state got=%b want=00000", got);
        end
        @(negedge clk);
        rst_n = 1'b1;
        settle("reset_idle");
        for (int k = 1; k <= LAT + 8; k++) begin
            tick(1'b1, model(k, LAT));
            vectors++;
            if (got !== want) begin
                errors++;
                $display("FAIL reset_pre k=%0d got=%b want=%b", k, got, want);
            end
        end
        #2 rst_n = 1'b0;
        #1;
        got = {tone_a, tone_b, sel, busy, done};
        vectors++;
        if (got !== 5'b0) begin
            errors++;
            $display("FAIL reset_async got=%b want=00000", got);
        end
        button = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            tick(1'b0, 5'b0);
            vectors++;
            if (got !== want) begin
                errors++;
                $display("FAIL reset_after k=%0d got=%b want=%b", k, got, want);
            end
        end
    endtask

    task automatic test_bounce();
        logic b;
        for (int k = 1; k <= 30; k++) begin
            b = (k <= 3) || (k == 6) || (k == 7);
            tick(b, 5'b0);
            vectors++;
            if (got !== want) begin
                errors++;
                $display("FAIL bounce k=%0d got=%b want=%b", k, got, want);
            end
        end
        settle("bounce");
    endtask

    task automatic test_clean_press();
        for (int k = 1; k <= 70; k++) begin
            tick(k <= 10, model(k, LAT));
            vectors++;
            if (got !== want) begin
                errors++;
                $display("FAIL clean k=%0d got=%b want=%b", k, got, want);
            end
        end
        settle("clean");
    endtask

    task automatic test_held();
        int dones = 0;
        for (int k = 1; k <= 200; k++) begin
            tick(1'b1, model(k, LAT));
            dones += int'(done);
            vectors++;
            if (got !== want) begin
                errors++;
                $display("FAIL held k=%0d got=%b want=%b", k, got, want);
            end
        end
        vectors++;
        if (dones !== 1) begin
            errors++;
            $display("FAIL held_done_count got=%0d want=1", dones);
        end
        settle("held");
    endtask

    task automatic test_press_dong();
        int dones = 0;
        int busies = 0;
        int p2 = 30 + LAT - 1;
        int p;
        int exp_busy;
        for (int k = 1; k <= 110; k++) begin
            p = LAT;
`ifdef CHIME_RETRIGGER_EN
            if (k >= p2) p = p2;
`endif
            tick((k <= 8) || (k >= 30 && k <= 40), model(k, p));
            dones  += int'(done);
            busies += int'(busy);
            vectors++;
            if (got !== want) begin
                errors++;
                $display("FAIL press_dong k=%0d got=%b want=%b", k, got, want);
            end
        end
`ifdef CHIME_RETRIGGER_EN
        exp_busy = (p2 - LAT) + DUR_A + DUR_B;
`else
        exp_busy = DUR_A + DUR_B;
`endif
        vectors++;
        if (busies !== exp_busy) begin
            errors++;
            $display("FAIL press_dong_busy got=%0d want=%0d", busies, exp_busy);
        end
        vectors++;
        if (dones !== 1) begin
            errors++;
            $display("FAIL press_dong_done_count got=%0d want=1", dones);
        end
        settle("press_dong");
    endtask

    initial begin
        #1;
        test_reset();
        test_bounce();
        test_clean_press();
        test_held();
        test_press_dong();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end
endmodule
